// File: rtl/line_buf_ctrl.sv
// -----------------------------------------------------------------------------
// line_buf_ctrl
//
// Sequencer for the two-FIFO line shift buffer that feeds the 3x3 window
// filters. Tracks the pixel/line position from the incoming video timing and
// drives both line FIFOs so that each one holds exactly one delayed line:
//   FIFO 0 holds line v-1 (written from the input stream),
//   FIFO 1 holds line v-2 (written from FIFO 0 read data).
// win_de marks a valid 3x3 window column. It is aligned with the FIFO read data,
// which arrives one cycle after the read.
//
// Parameters
//   H_ACTIVE     active pixels per line (>= 2)
//   V_ACTIVE     active lines per frame (>= 4)
//
// Ports
//   clk          pixel clock
//   rst          synchronous reset, active-high
//   in_vs        vertical sync; a rising edge restarts the frame
//   in_de        active-video data enable
//   fifo0_wr_en  FIFO 0 write enable, lines 0..V-2
//   fifo0_rd_en  FIFO 0 read enable, lines 1..V-1
//   fifo1_wr_en  FIFO 1 write enable, lines 1..V-2
//   fifo1_rd_en  FIFO 1 read enable, lines 2..V-1
//   fifo_flush   one-cycle pulse, OR'd into both FIFO resets
//   win_de       window column valid, fifo1_rd_en delayed one cycle
//   h_cnt        current pixel index
//   v_cnt        current line index
//   line_err     one-cycle pulse on a malformed line or frame
//
// Build option
//   LBC_ERR_RECOVER_EN  when defined, enables short-line and extra-line
//                       detection. A short line pulses line_err and fifo_flush
//                       and drops to IDLE until the next vsync. Beats in DONE
//                       pulse line_err. When undefined, line_err is tied low.
// -----------------------------------------------------------------------------
module line_buf_ctrl #(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vs,
    input  logic        in_de,
    output logic        fifo0_wr_en,
    output logic        fifo0_rd_en,
    output logic        fifo1_wr_en,
    output logic        fifo1_rd_en,
    output logic        fifo_flush,
    output logic        win_de,
    output logic [11:0] h_cnt,
    output logic [11:0] v_cnt,
    output logic        line_err
);

    localparam logic [11:0] H_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] V_PEN  = 12'(V_ACTIVE - 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LINE0  = 3'd1,
        LINE1  = 3'd2,
        STEADY = 3'd3,
        LAST   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;
    logic        vs_q;
    logic        win_q;
    logic        flush_q, flush_d;

    logic        vs_rise;
    logic        in_frame;
    logic        beat;
    logic        line_wrap;

    assign vs_rise   = in_vs & ~vs_q;
    assign in_frame  = (state_q == LINE0) || (state_q == LINE1) ||
                       (state_q == STEADY) || (state_q == LAST);
    // A beat in the vsync cycle is dropped, so the new frame starts clean.
    assign beat      = in_de & in_frame & ~vs_rise;
    assign line_wrap = beat & (h_q == H_LAST);

`ifdef LBC_ERR_RECOVER_EN
    logic de_q;
    logic err_q;
    logic short_line;
    logic extra_beat;

    // Short line: the data enable drops before the pixel counter has wrapped.
    assign short_line = in_frame & ~vs_rise & de_q & ~in_de & (h_q != '0);
    assign extra_beat = (state_q == DONE) & in_de & ~vs_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            de_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            de_q  <= in_de;
            err_q <= short_line | extra_beat;
        end
    end

    assign line_err = err_q;
`else
    assign line_err = 1'b0;
`endif

    // Next state, counters and flush request.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        flush_d = 1'b0;

        if (vs_rise) begin
            state_d = LINE0;
            h_d     = '0;
            v_d     = '0;
            // IDLE and DONE leave both FIFOs empty, so only a mid-frame vsync
            // must discard partial contents.
            flush_d = in_frame;
        end
`ifdef LBC_ERR_RECOVER_EN
        else if (short_line) begin
            state_d = IDLE;
            h_d     = '0;
            v_d     = '0;
            flush_d = 1'b1;
        end
`endif
        else if (beat) begin
            if (line_wrap) begin
                h_d = '0;
                v_d = v_q + 12'd1;
                unique case (state_q)
                    LINE0:  state_d = LINE1;
                    LINE1:  state_d = STEADY;
                    STEADY: if (v_q == V_PEN) state_d = LAST;
                    LAST: begin
                        state_d = DONE;
                        v_d     = '0;
                    end
                    default: state_d = state_q;
                endcase
            end else begin
                h_d = h_q + 12'd1;
            end
        end
    end

    // FIFO enables follow in_de with zero latency.
    always_comb begin
        fifo0_wr_en = 1'b0;
        fifo0_rd_en = 1'b0;
        fifo1_wr_en = 1'b0;
        fifo1_rd_en = 1'b0;
        if (beat) begin
            unique case (state_q)
                LINE0: begin
                    fifo0_wr_en = 1'b1;
                end
                LINE1: begin
                    fifo0_wr_en = 1'b1;
                    fifo0_rd_en = 1'b1;
                    fifo1_wr_en = 1'b1;
                end
                STEADY: begin
                    fifo0_wr_en = 1'b1;
                    fifo0_rd_en = 1'b1;
                    fifo1_wr_en = 1'b1;
                    fifo1_rd_en = 1'b1;
                end
                LAST: begin
                    fifo0_rd_en = 1'b1;
                    fifo1_rd_en = 1'b1;
                end
                default: begin
                    fifo0_wr_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            vs_q    <= 1'b0;
            win_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            vs_q    <= in_vs;
            win_q   <= fifo1_rd_en;
            flush_q <= flush_d;
        end
    end

    assign fifo_flush = flush_q;
    assign win_de     = win_q;
    assign h_cnt      = h_q;
    assign v_cnt      = v_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
module tb_line_buf_ctrl;

    localparam int H = 8;
    localparam int V = 6;

    logic        clk = 1'b0;
    logic        rst, in_vs, in_de;
    logic        fifo0_wr_en, fifo0_rd_en, fifo1_wr_en, fifo1_rd_en;
    logic        fifo_flush, win_de, line_err;
    logic [11:0] h_cnt, v_cnt;

    line_buf_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk(clk), .rst(rst), .in_vs(in_vs), .in_de(in_de),
        .fifo0_wr_en(fifo0_wr_en), .fifo0_rd_en(fifo0_rd_en),
        .fifo1_wr_en(fifo1_wr_en), .fifo1_rd_en(fifo1_rd_en),
        .fifo_flush(fifo_flush), .win_de(win_de),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .line_err(line_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: frame phase (0 = waiting for vsync, 1 = in frame,
    // 2 = frame complete), pixel/line position, and the previous vs/de inputs.
    int   m_mode, m_h, m_v;
    logic m_pvs, m_pde;

    int c_f0w, c_f0r, c_f1w, c_f1r, c_win, c_flush, c_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        c_f0w = 0; c_f0r = 0; c_f1w = 0; c_f1r = 0;
        c_win = 0; c_flush = 0; c_err = 0;
    endtask

    // One clock cycle: drive inputs, check combinational enables against the
    // model, advance the model across the edge, then check registered outputs.
    task automatic step(input logic r, input logic vs, input logic de);
        logic       vr, run, acc, err, flush;
        logic [3:0] en;
        rst = r; in_vs = vs; in_de = de;
        #1;
        vr    = vs & ~m_pvs;
        run   = (m_mode == 1);
        acc   = run & de & ~vr;
        en[3] = acc && (m_v <= V - 2);
        en[2] = acc && (m_v >= 1);
        en[1] = acc && (m_v >= 1) && (m_v <= V - 2);
        en[0] = acc && (m_v >= 2);
        check("enables", {fifo0_wr_en, fifo0_rd_en, fifo1_wr_en, fifo1_rd_en}, en);
        c_f0w += int'(fifo0_wr_en); c_f0r += int'(fifo0_rd_en);
        c_f1w += int'(fifo1_wr_en); c_f1r += int'(fifo1_rd_en);
`ifdef LBC_ERR_RECOVER_EN
        err = (run & ~vr & m_pde & ~de & (m_h != 0)) | ((m_mode == 2) & de & ~vr);
`else
        err = 1'b0;
`endif
        flush = vr & run;
        @(posedge clk);
        #1;
        if (r) begin
            m_mode = 0; m_h = 0; m_v = 0;
            en = '0; err = 1'b0; flush = 1'b0;
            m_pvs = 1'b0; m_pde = 1'b0;
        end else begin
            if (vr) begin
                m_mode = 1; m_h = 0; m_v = 0;
            end else if (run && err) begin
                m_mode = 0; m_h = 0; m_v = 0; flush = 1'b1;
            end else if (acc) begin
                if (m_h == H - 1) begin
                    m_h = 0;
                    if (m_v == V - 1) begin
                        m_v = 0; m_mode = 2;
                    end else begin
                        m_v++;
                    end
                end else begin
                    m_h++;
                end
            end
            m_pvs = vs; m_pde = de;
        end
        check("win_de", win_de, en[0]);
        check("fifo_flush", fifo_flush, flush);
        check("line_err", line_err, err);
        check("h_cnt", h_cnt, m_h);
        check("v_cnt", v_cnt, m_v);
        c_win += int'(win_de); c_flush += int'(fifo_flush); c_err += int'(line_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic vs_pulse();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic line(input int n, input int gap);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
        idle(gap);
    endtask

    task automatic check_frame_counts(input string tag);
        check({tag, "_f0w"}, c_f0w, 40);
        check({tag, "_f0r"}, c_f0r, 40);
        check({tag, "_f1w"}, c_f1w, 32);
        check({tag, "_f1r"}, c_f1r, 32);
        check({tag, "_win"}, c_win, 32);
    endtask

    initial begin
        rst = 1'b1; in_vs = 1'b0; in_de = 1'b0;
        m_mode = 0; m_h = 0; m_v = 0; m_pvs = 1'b0; m_pde = 1'b0;
        clr_counts();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {fifo0_wr_en, fifo0_rd_en, fifo1_wr_en, fifo1_rd_en, fifo_flush,
               win_de, line_err, h_cnt, v_cnt}, 32'd0);

        // in_de before any vsync is ignored.
        step(1'b0, 1'b0, 1'b0);
        clr_counts();
        line(H, 4);
        check("novs_en", c_f0w + c_f0r + c_f1w + c_f1r, 0);
        check("novs_h", h_cnt, 0);

        // Full frame with 4-cycle gaps.
        vs_pulse();
        clr_counts();
        for (int l = 0; l < V; l++) line(H, 4);
        check_frame_counts("frame1");
        check("frame1_flush", c_flush, 0);

        // Extra line in DONE.
        clr_counts();
        line(H, 4);
        check("done_en", c_f0w + c_f0r + c_f1w + c_f1r, 0);
`ifdef LBC_ERR_RECOVER_EN
        check("done_err", c_err, 8);
`else
        check("done_err", c_err, 0);
`endif

        // vsync during line 3 restarts the frame.
        vs_pulse();
        for (int l = 0; l < 3; l++) line(H, 4);
        line(4, 0);
        clr_counts();
        vs_pulse();
        check("midvs_flush", c_flush, 1);
        check("midvs_h", h_cnt, 0);
        check("midvs_v", v_cnt, 0);
        clr_counts();
        for (int l = 0; l < V; l++) line(H, 4);
        check_frame_counts("frame2");

        // 5-beat short line at line 2.
        vs_pulse();
        line(H, 4);
        line(H, 4);
        clr_counts();
        line(5, 4);
`ifdef LBC_ERR_RECOVER_EN
        check("short_err", c_err, 1);
        check("short_flush", c_flush, 1);
        clr_counts();
        line(H, 4);
        check("short_idle_en", c_f0w + c_f0r + c_f1w + c_f1r, 0);
        check("short_idle_h", h_cnt, 0);
`else
        check("short_err", c_err, 0);
        check("short_h", h_cnt, 5);
        line(H, 4);
`endif

        // Reset at pixel 4 of line 3, with in_de held high.
        vs_pulse();
        for (int l = 0; l < 3; l++) line(H, 4);
        line(4, 0);
        step(1'b1, 1'b0, 1'b1);
        check("rst_outputs",
              {fifo0_wr_en, fifo0_rd_en, fifo1_wr_en, fifo1_rd_en, fifo_flush,
               win_de, line_err, h_cnt, v_cnt}, 32'd0);
        clr_counts();
        line(H, 2);
        check("rst_idle_en", c_f0w + c_f0r + c_f1w + c_f1r, 0);

        // Randomized frames: random gaps, occasional short lines, extra lines,
        // aborted frames and resets, all checked cycle by cycle by the model.
        for (int f = 0; f < 10; f++) begin
            int nl;
            if ($urandom_range(0, 7) == 0) step(1'b1, 1'b0, 1'b0);
            vs_pulse();
            nl = V + int'($urandom_range(0, 1));
            for (int l = 0; l < nl; l++) begin
                int len;
                len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, H - 1)) : H;
                if ($urandom_range(0, 19) == 0) begin
                    line(len / 2, 0);
                    break;
                end
                line(len, int'($urandom_range(1, 4)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
